// File: rtl/emif_rd_launch_if.sv
// EMIF read-launch bundle: external strobe pins, the internal
// read req/ack handshake and the pad-side launch outputs.
interface emif_rd_launch_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
);
   logic                  emif_cs_n;
   logic                  emif_oe_n;
   logic [ADDR_WIDTH-1:0] emif_addr;
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_ack;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_oe;
   logic                  timeout_err;

   modport master (
      input  emif_cs_n, emif_oe_n, emif_addr,
      input  rd_ack, rd_data,
      output rd_req, rd_addr,
      output data_out, data_oe, timeout_err
   );

   modport slave (
      output emif_cs_n, emif_oe_n, emif_addr,
      output rd_ack, rd_data,
      input  rd_req, rd_addr,
      input  data_out, data_oe, timeout_err
   );
endinterface

// File: rtl/emif_rd_launch.sv
// Read-data launch stage: syncs the EMIF read strobe, fetches the
// word over req/ack and drives it for strobe plus hold time.
module emif_rd_launch #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 12,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 63
) (
   input  logic              clk,
   input  logic              rst,
   emif_rd_launch_if.master  bus
);
   localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
   localparam int HW_RAW = $clog2(HOLD_CYCLES + 1);
   localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;

   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [HW-1:0] H_LOAD = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] H_ONE  = HW'(1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRIVE,
      HOLD
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] cs_sync, oe_sync, vld;
   logic                   oe_d, armed;
   logic                   cs_s, oe_s, start, stop;

   logic [TW-1:0]         tcnt, tcnt_n;
   logic [HW-1:0]         hcnt, hcnt_n;
   logic                  req_q, req_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [DATA_WIDTH-1:0] dout_q, dout_n;
   logic                  oe_q, oe_n;
   logic                  terr_q, terr_n;

   assign cs_s = cs_sync[SYNC_STAGES-1];
   assign oe_s = oe_sync[SYNC_STAGES-1];

   // After reset the chain reads 1, which would fake a falling edge if
   // the strobe is already low; a real high level must be seen first.
   assign start = armed & ~cs_s & ~oe_s & oe_d;
   assign stop  = oe_s | cs_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync <= '1;
         oe_sync <= '1;
         vld     <= '0;
         oe_d    <= 1'b1;
         armed   <= 1'b0;
      end else begin
         cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus.emif_cs_n};
         oe_sync <= {oe_sync[SYNC_STAGES-2:0], bus.emif_oe_n};
         vld     <= {vld[SYNC_STAGES-2:0], 1'b1};
         oe_d    <= oe_s;
         armed   <= armed | (vld[SYNC_STAGES-1] & oe_s);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         tcnt   <= '0;
         hcnt   <= '0;
         req_q  <= 1'b0;
         addr_q <= '0;
         dout_q <= '0;
         oe_q   <= 1'b0;
         terr_q <= 1'b0;
      end else begin
         state  <= state_n;
         tcnt   <= tcnt_n;
         hcnt   <= hcnt_n;
         req_q  <= req_n;
         addr_q <= addr_n;
         dout_q <= dout_n;
         oe_q   <= oe_n;
         terr_q <= terr_n;
      end
   end

   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      hcnt_n  = hcnt;
      req_n   = req_q;
      addr_n  = addr_q;
      dout_n  = dout_q;
      oe_n    = oe_q;
      terr_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               addr_n  = bus.emif_addr;
               req_n   = 1'b1;
               tcnt_n  = '0;
               state_n = REQ;
            end
         end
         REQ: begin
            if (tcnt != T_MAX) tcnt_n = tcnt + 1'b1;
            if (bus.rd_ack) begin
               dout_n  = bus.rd_data;
               oe_n    = 1'b1;
               req_n   = 1'b0;
               state_n = DRIVE;
            end else if (stop) begin
               req_n   = 1'b0;
               state_n = IDLE;
            end else if (tcnt >= T_MAX - 1'b1) begin
               dout_n  = '0;
               oe_n    = 1'b1;
               req_n   = 1'b0;
               terr_n  = 1'b1;
               state_n = DRIVE;
            end
         end
         DRIVE: begin
            if (stop) begin
               if (HOLD_CYCLES == 0) begin
                  oe_n    = 1'b0;
                  state_n = IDLE;
               end else begin
                  hcnt_n  = H_LOAD;
                  state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (start) begin
               addr_n  = bus.emif_addr;
               req_n   = 1'b1;
               tcnt_n  = '0;
               state_n = REQ;
            end else begin
               if (hcnt != '0) hcnt_n = hcnt - 1'b1;
               if (hcnt <= H_ONE) begin
                  oe_n    = 1'b0;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.rd_req      = req_q;
   assign bus.rd_addr     = addr_q;
   assign bus.data_out    = dout_q;
   assign bus.data_oe     = oe_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_emif_rd_launch.sv
// Scenario bench for emif_rd_launch: scoreboard queues hold the
// expected address/data, popped as the DUT presents them.
module tb_emif_rd_launch;
   logic clk;
   logic rst;
   int   nchecks;
   int   nerrors;
   int   req_rises;
   logic req_prev;

   logic [11:0] exp_addr[$];
   logic [15:0] exp_data[$];

   emif_rd_launch_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus();

   emif_rd_launch #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(12),
      .SYNC_STAGES(2),
      .HOLD_CYCLES(2),
      .TIMEOUT_CYCLES(63)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial req_prev = 1'b0;
   initial req_rises = 0;
   always @(negedge clk) begin
      if (bus.rd_req === 1'b1 && req_prev !== 1'b1) req_rises++;
      req_prev = bus.rd_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_low(input logic [11:0] a);
      bus.emif_addr = a;
      bus.emif_cs_n = 1'b0;
      bus.emif_oe_n = 1'b0;
   endtask

   task automatic strobe_high();
      bus.emif_cs_n = 1'b1;
      bus.emif_oe_n = 1'b1;
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++)
         if (!ok) begin
            tick();
            ok = (bus.rd_req === 1'b1);
         end
   endtask

   task automatic wait_oe_low(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++)
         if (!ok) begin
            tick();
            ok = (bus.data_oe === 1'b0);
         end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      strobe_high();
      bus.emif_addr = '0;
      bus.rd_ack    = 1'b0;
      bus.rd_data   = '0;
      repeat (3) tick();
      nchecks++;
      if (bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL reset_rd_req: got %b want 0", bus.rd_req);
      end
      nchecks++;
      if (bus.rd_addr !== 12'h000) begin
         nerrors++;
         $display("FAIL reset_rd_addr: got %h want 000", bus.rd_addr);
      end
      nchecks++;
      if (bus.data_out !== 16'h0000) begin
         nerrors++;
         $display("FAIL reset_data_out: got %h want 0000", bus.data_out);
      end
      nchecks++;
      if (bus.data_oe !== 1'b0) begin
         nerrors++;
         $display("FAIL reset_data_oe: got %b want 0", bus.data_oe);
      end
      nchecks++;
      if (bus.timeout_err !== 1'b0) begin
         nerrors++;
         $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err);
      end
      rst = 1'b0;
      repeat (6) tick();
      nchecks++;
      if (bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL idle_rd_req: got %b want 0", bus.rd_req);
      end
   endtask

   task automatic test_single_read();
      int r0;
      logic [11:0] ea;
      logic [15:0] ed;
      r0 = req_rises;
      exp_addr.push_back(12'h123);
      tick();
      strobe_low(12'h123);
      tick();
      tick();
      nchecks++;
      if (bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL single_req_early: got %b want 0", bus.rd_req);
      end
      tick();
      nchecks++;
      if (bus.rd_req !== 1'b1) begin
         nerrors++;
         $display("FAIL single_req_latency: got %b want 1", bus.rd_req);
      end
      ea = exp_addr.pop_front();
      nchecks++;
      if (bus.rd_addr !== ea) begin
         nerrors++;
         $display("FAIL single_rd_addr: got %h want %h", bus.rd_addr, ea);
      end
      tick();
      tick();
      bus.rd_data = 16'hA5C3;
      bus.rd_ack  = 1'b1;
      exp_data.push_back(16'hA5C3);
      tick();
      bus.rd_ack = 1'b0;
      ed = exp_data.pop_front();
      nchecks++;
      if (bus.data_out !== ed || bus.data_oe !== 1'b1 || bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL single_ack: got data %h oe %b req %b want %h 1 0",
                  bus.data_out, bus.data_oe, bus.rd_req, ed);
      end
      repeat (6) tick();
      strobe_high();
      repeat (4) tick();
      nchecks++;
      if (bus.data_oe !== 1'b1) begin
         nerrors++;
         $display("FAIL single_hold_oe: got %b want 1", bus.data_oe);
      end
      tick();
      nchecks++;
      if (bus.data_oe !== 1'b0 || bus.data_out !== ed) begin
         nerrors++;
         $display("FAIL single_oe_off: got oe %b data %h want 0 %h",
                  bus.data_oe, bus.data_out, ed);
      end
      nchecks++;
      if (req_rises - r0 != 1) begin
         nerrors++;
         $display("FAIL single_req_pulses: got %0d want 1", req_rises - r0);
      end
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      bit ok;
      bit seen;
      int n;
      logic [11:0] ea;
      logic [15:0] ed;
      exp_addr.push_back(12'h0AA);
      tick();
      strobe_low(12'h0AA);
      wait_req(10, ok);
      ea = exp_addr.pop_front();
      nchecks++;
      if (!ok || bus.rd_addr !== ea) begin
         nerrors++;
         $display("FAIL timeout_req: got req %b addr %h want 1 %h", ok, bus.rd_addr, ea);
      end
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++)
         if (!seen) begin
            tick();
            n++;
            seen = (bus.timeout_err === 1'b1);
         end
      nchecks++;
      if (!seen || n != 63) begin
         nerrors++;
         $display("FAIL timeout_cycles: got seen %b after %0d want 1 after 63", seen, n);
      end
      exp_data.push_back(16'h0000);
      ed = exp_data.pop_front();
      nchecks++;
      if (bus.data_out !== ed || bus.data_oe !== 1'b1 || bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL timeout_drive: got data %h oe %b req %b want %h 1 0",
                  bus.data_out, bus.data_oe, bus.rd_req, ed);
      end
      tick();
      nchecks++;
      if (bus.timeout_err !== 1'b0) begin
         nerrors++;
         $display("FAIL timeout_pulse: got %b want 0", bus.timeout_err);
      end
      strobe_high();
      wait_oe_low(10, ok);
      nchecks++;
      if (!ok) begin
         nerrors++;
         $display("FAIL timeout_release: got oe %b want 0", bus.data_oe);
      end
      repeat (3) tick();
   endtask

   task automatic test_abort();
      bit ok;
      bit dropped;
      logic [11:0] ea;
      logic [15:0] prev;
      prev = 16'h0000;
      exp_addr.push_back(12'h3F0);
      tick();
      strobe_low(12'h3F0);
      wait_req(10, ok);
      ea = exp_addr.pop_front();
      nchecks++;
      if (!ok || bus.rd_addr !== ea) begin
         nerrors++;
         $display("FAIL abort_req: got req %b addr %h want 1 %h", ok, bus.rd_addr, ea);
      end
      tick();
      bus.emif_oe_n = 1'b1;
      dropped = 1'b0;
      for (int i = 0; i < 10; i++)
         if (!dropped) begin
            tick();
            dropped = (bus.rd_req === 1'b0);
         end
      nchecks++;
      if (!dropped || bus.data_oe !== 1'b0) begin
         nerrors++;
         $display("FAIL abort_drop: got dropped %b oe %b want 1 0", dropped, bus.data_oe);
      end
      bus.rd_data = 16'hDEAD;
      bus.rd_ack  = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      tick();
      nchecks++;
      if (bus.data_out !== prev || bus.data_oe !== 1'b0 || bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL abort_late_ack: got data %h oe %b req %b want %h 0 0",
                  bus.data_out, bus.data_oe, bus.rd_req, prev);
      end
      strobe_high();
      repeat (4) tick();
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit drop;
      logic [11:0] ea;
      logic [15:0] ed;
      logic [15:0] first;
      exp_addr.push_back(12'h123);
      tick();
      strobe_low(12'h123);
      wait_req(10, ok);
      ea = exp_addr.pop_front();
      nchecks++;
      if (!ok || bus.rd_addr !== ea) begin
         nerrors++;
         $display("FAIL b2b_req1: got req %b addr %h want 1 %h", ok, bus.rd_addr, ea);
      end
      exp_data.push_back(16'h1111);
      bus.rd_data = 16'h1111;
      bus.rd_ack  = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      first = exp_data.pop_front();
      repeat (3) tick();
      bus.emif_oe_n = 1'b1;
      tick();
      tick();
      exp_addr.push_back(12'h124);
      bus.emif_addr = 12'h124;
      bus.emif_oe_n = 1'b0;
      tick();
      tick();
      nchecks++;
      if (bus.data_oe !== 1'b1 || bus.rd_req !== 1'b0) begin
         nerrors++;
         $display("FAIL b2b_hold: got oe %b req %b want 1 0", bus.data_oe, bus.rd_req);
      end
      tick();
      ea = exp_addr.pop_front();
      nchecks++;
      if (bus.rd_req !== 1'b1 || bus.rd_addr !== ea || bus.data_oe !== 1'b1) begin
         nerrors++;
         $display("FAIL b2b_req2: got req %b addr %h oe %b want 1 %h 1",
                  bus.rd_req, bus.rd_addr, bus.data_oe, ea);
      end
      drop = 1'b0;
      tick();
      drop |= (bus.data_oe !== 1'b1);
      nchecks++;
      if (bus.data_out !== first) begin
         nerrors++;
         $display("FAIL b2b_data_held: got %h want %h", bus.data_out, first);
      end
      exp_data.push_back(16'h5A5A);
      bus.rd_data = 16'h5A5A;
      bus.rd_ack  = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      ed = exp_data.pop_front();
      nchecks++;
      if (bus.data_out !== ed || drop || bus.data_oe !== 1'b1) begin
         nerrors++;
         $display("FAIL b2b_ack2: got data %h drop %b oe %b want %h 0 1",
                  bus.data_out, drop, bus.data_oe, ed);
      end
      strobe_high();
      wait_oe_low(10, ok);
      nchecks++;
      if (!ok) begin
         nerrors++;
         $display("FAIL b2b_release: got oe %b want 0", bus.data_oe);
      end
      repeat (3) tick();
   endtask

   task automatic test_ack_timeout();
      bit ok;
      logic [11:0] ea;
      logic [15:0] ed;
      exp_addr.push_back(12'h055);
      tick();
      strobe_low(12'h055);
      wait_req(10, ok);
      ea = exp_addr.pop_front();
      nchecks++;
      if (!ok || bus.rd_addr !== ea) begin
         nerrors++;
         $display("FAIL acktmo_req: got req %b addr %h want 1 %h", ok, bus.rd_addr, ea);
      end
      repeat (62) tick();
      exp_data.push_back(16'h3C3C);
      bus.rd_data = 16'h3C3C;
      bus.rd_ack  = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      ed = exp_data.pop_front();
      nchecks++;
      if (bus.data_out !== ed || bus.timeout_err !== 1'b0 || bus.data_oe !== 1'b1) begin
         nerrors++;
         $display("FAIL acktmo_edge: got data %h terr %b oe %b want %h 0 1",
                  bus.data_out, bus.timeout_err, bus.data_oe, ed);
      end
      tick();
      nchecks++;
      if (bus.timeout_err !== 1'b0) begin
         nerrors++;
         $display("FAIL acktmo_after: got terr %b want 0", bus.timeout_err);
      end
      strobe_high();
      wait_oe_low(10, ok);
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      bit ok;
      bit spur;
      logic [11:0] ea;
      logic [15:0] ed;
      exp_addr.push_back(12'h777);
      tick();
      strobe_low(12'h777);
      wait_req(10, ok);
      ea = exp_addr.pop_front();
      exp_data.push_back(16'hBEEF);
      bus.rd_data = 16'hBEEF;
      bus.rd_ack  = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      ed = exp_data.pop_front();
      nchecks++;
      if (!ok || bus.rd_addr !== ea || bus.data_out !== ed) begin
         nerrors++;
         $display("FAIL rst_setup: got req %b addr %h data %h want 1 %h %h",
                  ok, bus.rd_addr, bus.data_out, ea, ed);
      end
      tick();
      #3;
      rst = 1'b1;
      #1;
      nchecks++;
      if (bus.data_oe !== 1'b0 || bus.data_out !== 16'h0000 ||
          bus.rd_req !== 1'b0 || bus.rd_addr !== 12'h000) begin
         nerrors++;
         $display("FAIL rst_async: got oe %b data %h req %b addr %h want 0 0000 0 000",
                  bus.data_oe, bus.data_out, bus.rd_req, bus.rd_addr);
      end
      tick();
      tick();
      rst = 1'b0;
      spur = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         spur |= (bus.rd_req !== 1'b0);
      end
      nchecks++;
      if (spur) begin
         nerrors++;
         $display("FAIL rst_no_reissue: got spurious req %b want 0", spur);
      end
      bus.emif_oe_n = 1'b1;
      repeat (4) tick();
      exp_addr.push_back(12'h777);
      bus.emif_oe_n = 1'b0;
      wait_req(10, ok);
      ea = exp_addr.pop_front();
      nchecks++;
      if (!ok || bus.rd_addr !== ea) begin
         nerrors++;
         $display("FAIL rst_fresh_req: got req %b addr %h want 1 %h", ok, bus.rd_addr, ea);
      end
      bus.rd_data = 16'h0F0F;
      bus.rd_ack  = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      strobe_high();
      wait_oe_low(10, ok);
      repeat (3) tick();
   endtask

   initial begin
      nchecks = 0;
      nerrors = 0;
      test_reset();
      test_single_read();
      test_timeout();
      test_abort();
      test_back_to_back();
      test_ack_timeout();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule

// File: doc/emif_rd_launch.md
# emif_rd_launch

Read-data launch stage of the asynchronous EMIF slave: detects an external EMIF read strobe, fetches the addressed word from the internal register/memory side over a req/ack handshake, and holds it on `data_out` for the duration of the strobe plus a programmable hold time. `data_out` feeds the pin output-buffer wrapper directly. `data_oe` goes to the top-level tristate control.

## Interface
- `DATA_WIDTH`, 16, read data width; must equal the output-buffer `DATA_WIDTH`.
- `ADDR_WIDTH`, 12, EMIF address width.
- `SYNC_STAGES`, 2, synchronizer depth for `emif_cs_n`/`emif_oe_n`; legal range 2..4.
- `HOLD_CYCLES`, 2, cycles the data is still driven after strobe end; 0 is legal.
- `TIMEOUT_CYCLES`, 63, maximum cycles waiting for `rd_ack`; ≥1.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `emif_cs_n` in 1: EMIF chip select, asynchronous to `clk`.
- `emif_oe_n` in 1: EMIF output enable / read strobe, asynchronous.
- `emif_addr` in ADDR_WIDTH: EMIF address, stable while `emif_cs_n` is low.
- `rd_req` out 1: internal read request, level.
- `rd_addr` out ADDR_WIDTH: internal read address, valid while `rd_req`=1.
- `rd_ack` in 1: internal read acknowledge, one-cycle pulse; `rd_data` is valid in the same cycle.
- `rd_data` in DATA_WIDTH: internal read data.
- `data_out` out DATA_WIDTH: launch data to the output buffer.
- `data_oe` out 1: pad drive enable.
- `timeout_err` out 1: one-cycle pulse when a request times out.

## Operation
- `cs_s` and `oe_s` are `emif_cs_n` and `emif_oe_n` passed through `SYNC_STAGES` flops. Synchronizer flops reset to 1. `oe_d` is `oe_s` delayed by one cycle.
- start = `cs_s`==0 && `oe_s`==0 && `oe_d`==1.
- end = `oe_s`==1 || `cs_s`==1.
- FSM states: IDLE, REQ, DRIVE, HOLD.
- IDLE, on start: latch `emif_addr` into `rd_addr`, set `rd_req`=1, clear the timeout counter, go to REQ.
- REQ, on `rd_ack`: register `rd_data` into `data_out`, set `data_oe`=1, set `rd_req`=0, go to DRIVE.
- REQ, on end before ack (master abort): set `rd_req`=0, go to IDLE. `data_out` and `data_oe` are unchanged.
- REQ, when the counter reaches TIMEOUT_CYCLES without ack: set `data_out`=0, `data_oe`=1, `rd_req`=0, pulse `timeout_err`, go to DRIVE.
- REQ priority: ack > abort > timeout.
- DRIVE: hold `data_out` and `data_oe`. On end, go to HOLD and load the hold counter with HOLD_CYCLES. If HOLD_CYCLES=0, go straight to IDLE and set `data_oe`=0.
- HOLD: decrement the hold counter each cycle. At 0, set `data_oe`=0 and go to IDLE.
- HOLD, on start (back-to-back read): abandon the remaining hold, latch the new address, set `rd_req`=1, go to REQ. `data_oe` stays 1 until the new ack or timeout.
- `rd_ack` outside REQ is ignored.
- `data_out` keeps its last value in IDLE; it is never cleared except by reset or timeout.
- Counter widths are `$clog2(TIMEOUT_CYCLES+1)` and `$clog2(HOLD_CYCLES+1)`, minimum 1. Counters saturate and never wrap.

## Timing
- Reset values: `rd_req`=0, `rd_addr`=0, `data_out`=0, `data_oe`=0, `timeout_err`=0, FSM=IDLE, sync flops=1, counters=0.
- All outputs are registered.
- Start detection: `oe_n` low first sampled at edge k → `rd_req`=1 after edge k+SYNC_STAGES.
- Ack sampled at edge m → `data_out`, `data_oe` valid and `rd_req`=0 after edge m.
- Pin-to-data latency = SYNC_STAGES + 1 + ack latency, in cycles. EMIF strobe and setup timing must be configured to cover it plus output-buffer delay.
- `oe_n` rising first sampled at edge j → `data_oe`=0 after edge j+SYNC_STAGES+HOLD_CYCLES.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). No request is re-issued after release until a fresh `oe_n` falling edge is seen.

## Test plan
- Single read, SYNC_STAGES=2: `emif_addr`=0x123, strobe low for 12 cycles, `rd_ack` 3 cycles after `rd_req` with `rd_data`=0xA5C3 → `rd_addr`=0x123, `data_out`=0xA5C3, `data_oe` high until 2+2 cycles after `oe_n` rises, one `rd_req` pulse.
- Timeout: strobe held low, no ack → after 63 cycles in REQ `timeout_err` pulses once, `data_out`=0x0000 driven, `rd_req`=0.
- Abort: `oe_n` rises before ack → `rd_req` drops, FSM returns to IDLE, a late `rd_ack` is ignored, `data_oe` remains 0.
- Back-to-back: second `oe_n` fall (addr 0x124) during HOLD → new `rd_req` without `data_oe` dropping. `data_out` changes only on the second ack (0x5A5A).
- Simultaneous ack and timeout in the same cycle → ack data is driven, no `timeout_err`.
- Async reset asserted in DRIVE → `data_oe`/`data_out`/`rd_req` go to 0 immediately. With strobe still low at release, no new request is issued until the next falling edge.
